// File: rtl/addr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : addr_fetch_buffer
// Brief    : Issues generator addresses to a 1-cycle-latency buffer memory,
//            queues the returned words (with their last marker) in a small
//            FIFO and hands them to the PE over valid/ready. Credits cover
//            FIFO entries plus the one read in flight, so no return is lost.
// Options  : FETCH_RANGE_CHECK_EN - addresses >= MEM_DEPTH are not read; a
//            zero word is queued instead and rangeErr is set sticky.
// Revision : 1.0 - initial release
// ============================================================================
module addr_fetch_buffer #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int MEM_DEPTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          adrIn,
  input  logic                       adrValid,
  input  logic                       lastIn,
  output logic                       adrReady,
  input  logic                       flush,
  output logic [ADDR_W-1:0]          memAddr,
  output logic                       memRen,
  input  logic [DATA_W-1:0]          memData,
  output logic [DATA_W-1:0]          dataOut,
  output logic                       dataLast,
  output logic                       dataValid,
  input  logic                       dataReady,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       rangeErr
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(DEPTH);

  logic [c_PTR_W-1:0] wptr_q, rptr_q;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic               inflight_q;
  logic               pend_last_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_mem_q [DEPTH];
  logic               last_mem_q [DEPTH];

  logic               w_accept;
  logic               w_clear;
  logic               w_capture;
  logic               w_pop;
  logic [c_CNT_W:0]   w_credit;
  logic [DATA_W-1:0]  w_cap_data;

  // Credits are taken from registered state only, so a pop frees a slot
  // one cycle later; this keeps adrReady free of a dataReady path.
  assign w_credit  = {1'b0, count_q} + {{c_CNT_W{1'b0}}, inflight_q};
  assign adrReady  = !flush && !rst && (w_credit < c_DEPTH);
  assign w_accept  = adrValid && adrReady;
  assign w_clear   = rst || flush;
  assign w_capture = inflight_q && !w_clear;
  assign dataValid = (count_q != '0);
  assign w_pop     = dataValid && dataReady && !w_clear;

  assign memAddr   = w_accept ? adrIn : addr_q;
  assign dataOut   = data_mem_q[rptr_q];
  assign dataLast  = dataValid && last_mem_q[rptr_q];
  assign count     = count_q;

`ifdef FETCH_RANGE_CHECK_EN
  logic w_oob;
  logic pend_oob_q;
  logic err_q;

  assign w_oob      = (32'(adrIn) >= 32'(MEM_DEPTH));
  assign memRen     = w_accept && !w_oob;
  assign w_cap_data = pend_oob_q ? '0 : memData;
  assign rangeErr   = err_q;

  // Out-of-range marker travels with the read; the error flag only clears on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_oob_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (w_accept) begin
        pend_oob_q <= w_oob;
      end
      if (w_accept && w_oob) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign memRen     = w_accept;
  assign w_cap_data = memData;
  assign rangeErr   = 1'b0;
`endif

  // Occupancy: push and pop in one cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (w_capture && !w_pop) begin
      count_d = count_q + c_CNT_W'(1);
    end else if (!w_capture && w_pop) begin
      count_d = count_q - c_CNT_W'(1);
    end
  end

  // Pointers, occupancy and the in-flight read; clear wins over everything.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (w_capture) begin
        wptr_q <= wptr_q + c_PTR_W'(1);
      end
      if (w_pop) begin
        rptr_q <= rptr_q + c_PTR_W'(1);
      end
      if (w_accept) begin
        inflight_q  <= 1'b1;
        pend_last_q <= lastIn;
      end else if (w_capture) begin
        inflight_q <= 1'b0;
      end
    end
  end

  // Memory address holds its last issued value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (w_accept) begin
      addr_q <= adrIn;
    end
  end

  // FIFO storage; contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      data_mem_q[wptr_q] <= w_cap_data;
      last_mem_q[wptr_q] <= pend_last_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr_fetch_buffer
// Brief    : Randomised plus directed bench for addr_fetch_buffer against a
//            queue-based model of the fetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addr_fetch_buffer;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int DP = 4;
  localparam int MD = 100;

  logic          clk;
  logic          rst;
  logic [AW-1:0] adrIn;
  logic          adrValid;
  logic          lastIn;
  logic          adrReady;
  logic          flush;
  logic [AW-1:0] memAddr;
  logic          memRen;
  logic [DW-1:0] memData;
  logic [DW-1:0] dataOut;
  logic          dataLast;
  logic          dataValid;
  logic          dataReady;
  logic [2:0]    count;
  logic          rangeErr;

  addr_fetch_buffer #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .MEM_DEPTH(MD)
  ) dut (
    .clk(clk), .rst(rst), .adrIn(adrIn), .adrValid(adrValid),
    .lastIn(lastIn), .adrReady(adrReady), .flush(flush),
    .memAddr(memAddr), .memRen(memRen), .memData(memData),
    .dataOut(dataOut), .dataLast(dataLast), .dataValid(dataValid),
    .dataReady(dataReady), .count(count), .rangeErr(rangeErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer memory: mem[a] = a + 10, one cycle read latency, junk otherwise.
  logic [DW-1:0] mem_arr [128];
  initial begin
    for (int i = 0; i < 128; i++) mem_arr[i] = DW'(i + 10);
  end
  always @(posedge clk) begin
    if (memRen) memData <= mem_arr[memAddr];
    else        memData <= DW'($urandom);
  end

  int n_vec = 0;
  int n_err = 0;

  // Model: queue of {last, data}, plus one pending read.
  logic [DW:0]   q [$];
  bit            pend, pend_oob, pend_last;
  logic [AW-1:0] pend_addr;
  logic [AW-1:0] last_addr;
  bit            err;
  bit            last_acc;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  task automatic step(input bit v, input logic [AW-1:0] a, input bit l,
                      input bit r, input bit f, input bit rs);
    bit exp_ready, acc, oob;
    logic [DW:0] h;
    @(negedge clk);
    adrValid = v; adrIn = a; lastIn = l; dataReady = r; flush = f; rst = rs;
    #1;
    exp_ready = !f && !rs && ((q.size() + int'(pend)) < DP);
    acc = v && exp_ready;
    oob = 1'b0;
`ifdef FETCH_RANGE_CHECK_EN
    oob = acc && (int'(a) >= MD);
`endif
    chk("adrReady", 32'(adrReady), 32'(exp_ready));
    chk("memRen", 32'(memRen), 32'(acc && !oob));
    chk("memAddr", 32'(memAddr), 32'(acc ? a : last_addr));
    chk("dataValid", 32'(dataValid), 32'(q.size() != 0));
    chk("count", 32'(count), 32'(q.size()));
    chk("rangeErr", 32'(rangeErr), 32'(err));
    if (q.size() != 0) begin
      h = q[0];
      chk("dataOut", 32'(dataOut), 32'(h[DW-1:0]));
      chk("dataLast", 32'(dataLast), 32'(h[DW]));
    end else begin
      chk("dataLast", 32'(dataLast), 32'd0);
    end
    last_acc = acc;
    if (rs || f) begin
      q.delete();
      pend = 1'b0;
      if (rs) begin
        err = 1'b0;
        last_addr = '0;
      end
    end else begin
      if (q.size() != 0 && r) void'(q.pop_front());
      if (pend) q.push_back({pend_last, (pend_oob ? {DW{1'b0}} : mem_arr[pend_addr])});
      pend = acc; pend_addr = a; pend_last = l; pend_oob = oob;
      if (acc) last_addr = a;
      if (oob) err = 1'b1;
    end
  endtask

  initial begin
    int nxt;
    pend = 0; pend_oob = 0; pend_last = 0; pend_addr = '0; last_addr = '0; err = 0;
    adrValid = 0; adrIn = '0; lastIn = 0; dataReady = 0; flush = 0; rst = 1;

    // Reset
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid", 32'(dataValid), 32'd0);
    chk("reset_memren", 32'(memRen), 32'd0);

    // Streaming 0..3 with consumer ready
    for (int k = 0; k < 6; k++) begin
      step(k < 4, AW'(k), 0, 1, 0, 0);
      if (k == 1) chk("t1_not_yet_valid", 32'(dataValid), 32'd0);
      if (k >= 2) begin
        chk("t1_valid", 32'(dataValid), 32'd1);
        chk("t1_data", 32'(dataOut), 32'(k + 8));
        chk("t1_count", 32'(count), 32'd1);
      end
    end

    // Backpressure: 6 addresses with consumer stalled, then drain
    nxt = 20;
    for (int k = 0; k < 6; k++) begin
      step(1, AW'(nxt), 0, 0, 0, 0);
      if (last_acc) nxt++;
      if (k == 4) chk("t2_ready_low", 32'(adrReady), 32'd0);
      if (k == 5) chk("t2_full", 32'(count), 32'd4);
    end
    for (int k = 0; k < 20; k++) begin
      step(nxt < 26, AW'(nxt), 0, 1, 0, 0);
      if (last_acc) nxt++;
      if (k == 0) chk("t2_first_drain", 32'(dataOut), 32'd30);
      if (k == 1) chk("t2_second_drain", 32'(dataOut), 32'd31);
    end
    chk("t2_all_accepted", 32'(nxt), 32'd26);

    // Last marker on third of three
    step(1, 40, 0, 1, 0, 0);
    step(1, 41, 0, 1, 0, 0);
    step(1, 42, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t4_last_low", 32'(dataLast), 32'd0);
    chk("t4_data41", 32'(dataOut), 32'd51);
    step(0, 0, 0, 1, 0, 0);
    chk("t4_last_high", 32'(dataLast), 32'd1);
    chk("t4_data42", 32'(dataOut), 32'd52);
    step(0, 0, 0, 1, 0, 0);

    // Flush right after an accept
    step(1, 5, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("t5_flush_ready", 32'(adrReady), 32'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("t5_flush_valid", 32'(dataValid), 32'd0);
    chk("t5_flush_count", 32'(count), 32'd0);
    chk("t5_flush_ready_back", 32'(adrReady), 32'd1);

    // Reset right after an accept
    step(1, 6, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("t5_rst_valid", 32'(dataValid), 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_ready_back", 32'(adrReady), 32'd1);

    // Range check
    step(1, 120, 0, 1, 0, 0);
`ifdef FETCH_RANGE_CHECK_EN
    chk("t6_memren", 32'(memRen), 32'd0);
`else
    chk("t6_memren", 32'(memRen), 32'd1);
`endif
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
`ifdef FETCH_RANGE_CHECK_EN
    chk("t6_data", 32'(dataOut), 32'd0);
    chk("t6_err", 32'(rangeErr), 32'd1);
`else
    chk("t6_data", 32'(dataOut), 32'd130);
    chk("t6_err", 32'(rangeErr), 32'd0);
`endif
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
`ifdef FETCH_RANGE_CHECK_EN
    chk("t6_err_after_flush", 32'(rangeErr), 32'd1);
`else
    chk("t6_err_after_flush", 32'(rangeErr), 32'd0);
`endif

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 127)),
           ($urandom % 4) == 0, $urandom_range(0, 3) != 0,
           ($urandom % 50) == 0, ($urandom % 200) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
